// File: rtl/dcache_pkg.sv
// Shared types and address-geometry helpers for the set-associative data cache.
package dcache_pkg;

  localparam int OFF = 5;

  typedef enum logic [1:0] {IDLE, WB, RF, DONE} state_e;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - OFF - $clog2(sets);
  endfunction

  // Width of a way pointer / age field; a single way still needs one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set age-based LRU tracker: ages form a permutation 0..WAYS-1, MRU = 0.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 16,
  localparam int IW  = idx_w(SETS),
  localparam int AW  = ptr_w(WAYS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [IW-1:0] set_i,
  input  logic          touch_i,
  input  logic [AW-1:0] way_i,
  output logic [AW-1:0] victim_o
);

  logic [AW-1:0] age_q [SETS][WAYS];

  // Cleared state is way w at age w, so every set starts as a valid permutation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AW'(w);
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == way_i)
          age_q[set_i][w] <= '0;
        else if (age_q[set_i][w] < age_q[set_i][way_i])
          age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[set_i][w] == AW'(WAYS - 1)) victim_o = AW'(w);
  end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// WAYS-way set-associative write-back/write-allocate data cache controller
// with LRU replacement and saturating hit/miss counters.
module dcache_assoc_ctrl
  import dcache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(ADDR_W, SETS);
  localparam int WW = ptr_w(WAYS);

  state_e          state_q, state_d;
  logic [WW-1:0]   vic_q;
  logic            retry_q;
  logic [31:0]     hit_cnt_q, miss_cnt_q;
  logic [SETS-1:0] valid_q [WAYS];
  logic [SETS-1:0] dirty_q [WAYS];
  logic [TW-1:0]   tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q [WAYS][SETS];

  logic [IW-1:0]    idx;
  logic [TW-1:0]    tag;
  logic [OFF-3:0]   wsel;
  logic [1:0]       addr_lo_unused;
  logic             req, wr, rd_only;
  logic [WAYS-1:0]  hit_vec;
  logic             hit, any_inv, touch, miss_idle, refill;
  logic [WW-1:0]    hit_way, inv_way, lru_vic, victim;

  assign idx            = cpu_addr_i[OFF +: IW];
  assign tag            = cpu_addr_i[ADDR_W-1 -: TW];
  assign wsel           = cpu_addr_i[OFF-1:2];
  assign addr_lo_unused = cpu_addr_i[1:0];
  assign req            = cpu_MemRead_i | cpu_MemWrite_i;
  assign wr             = cpu_MemWrite_i;
  assign rd_only        = cpu_MemRead_i & ~cpu_MemWrite_i;

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WW'(w);
      if (!valid_q[w][idx]) begin
        any_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign hit       = |hit_vec;
  assign victim    = any_inv ? inv_way : lru_vic;
  assign touch     = (state_q == IDLE) && req && hit;
  assign miss_idle = (state_q == IDLE) && req && !hit;
  assign refill    = (state_q == RF) && mem_ack_i;

  dcache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_i    (idx),
    .touch_i  (touch),
    .way_i    (hit_way),
    .victim_o (lru_vic)
  );

  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      IDLE: if (miss_idle) begin
        cpu_stall_o = 1'b1;
        state_d     = dirty_q[victim][idx] ? WB : RF;
      end
      WB: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[vic_q][idx], idx, {OFF{1'b0}}};
        mem_data_o   = data_q[vic_q][idx];
        if (mem_ack_i) state_d = RF;
      end
      RF: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, idx, {OFF{1'b0}}};
        if (mem_ack_i) state_d = DONE;
      end
      DONE: begin
        cpu_stall_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_data_o = (touch && rd_only) ? data_q[hit_way][idx][wsel*DATA_W +: DATA_W] : '0;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  // The retried access right after DONE completes a miss, so it is not a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      vic_q      <= '0;
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      retry_q <= (state_q == DONE);
      if (miss_idle) vic_q <= victim;
      if (touch && !retry_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_idle && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (refill) begin
        valid_q[vic_q][idx] <= 1'b1;
        dirty_q[vic_q][idx] <= 1'b0;
      end
      if (touch && wr) dirty_q[hit_way][idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (refill) begin
      data_q[vic_q][idx] <= mem_data_i;
      tag_q[vic_q][idx]  <= tag;
    end
    if (touch && wr) data_q[hit_way][idx][wsel*DATA_W +: DATA_W] <= cpu_data_i;
  end

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// Directed table-driven bench for dcache_assoc_ctrl with a behavioural line memory.
module tb_dcache_assoc_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0, cpu_data_i = '0, cpu_data_o;
  logic         cpu_MemRead_i = 1'b0, cpu_MemWrite_i = 1'b0, cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i = '0;
  logic         mem_enable_o, mem_write_o, mem_ack_i = 1'b0;
  logic [31:0]  hit_cnt_o, miss_cnt_o;

  dcache_assoc_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Untouched memory: each word holds 0xA500_0000 + its own byte address.
  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA500_0000 + {a[31:5], 5'b0} + 32'(k * 4);
    return l;
  endfunction

  logic [255:0] mem [logic [31:0]];
  logic         logw [$];
  logic [31:0]  loga [$];
  logic [255:0] logd [$];
  int           lat = 3;

  // Ack pulses in the lat-th cycle that enable is seen high.
  initial begin
    int  cnt = 0;
    logic prev;
    forever begin
      @(negedge clk_i);
      prev = mem_ack_i;
      mem_ack_i = 1'b0;
      if (prev) cnt = 0;
      if (mem_enable_o) begin
        cnt++;
        if (cnt >= lat) begin
          mem_ack_i = 1'b1;
          cnt = 0;
          logw.push_back(mem_write_o);
          loga.push_back(mem_addr_o);
          if (mem_write_o) begin
            mem[mem_addr_o] = mem_data_o;
            logd.push_back(mem_data_o);
          end else begin
            mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : pat(mem_addr_o);
            logd.push_back(mem_data_i);
          end
        end
      end else cnt = 0;
    end
  end

  // Entered at posedge+1; returns at posedge+1 after the committing edge.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int stall, output logic [31:0] rdat);
    cpu_addr_i = a; cpu_data_i = d; cpu_MemRead_i = rd; cpu_MemWrite_i = wr;
    #3;
    stall = 0;
    while (cpu_stall_o && stall < 200) begin
      stall++;
      @(posedge clk_i); #4;
    end
    if (stall >= 200) chk("stall_timeout", 256'(stall), 256'(0));
    rdat = cpu_data_o;
    @(posedge clk_i); #1;
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    int          stall;
    logic        chk_rd;
    logic [31:0] rdata, hit, miss;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input int st, input logic c,
                              input logic [31:0] r, input logic [31:0] h, input logic [31:0] m);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.stall = st;
    v.chk_rd = c; v.rdata = r; v.hit = h; v.miss = m;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    int          st;
    logic [31:0] rdat;
    logic [255:0] wb_line;

    vecs[0]  = mk(1, 0, 32'h040, 0,            5, 1, 32'hA500_0040, 0, 1);
    vecs[1]  = mk(0, 1, 32'h044, 32'hDEADBEEF, 0, 0, 0,             1, 1);
    vecs[2]  = mk(1, 0, 32'h044, 0,            0, 1, 32'hDEADBEEF,  2, 1);
    vecs[3]  = mk(1, 0, 32'h240, 0,            5, 1, 32'hA500_0240, 2, 2);
    vecs[4]  = mk(1, 0, 32'h040, 0,            0, 1, 32'hA500_0040, 3, 2);
    vecs[5]  = mk(1, 0, 32'h440, 0,            5, 1, 32'hA500_0440, 3, 3);
    vecs[6]  = mk(1, 0, 32'h040, 0,            0, 1, 32'hA500_0040, 4, 3);
    vecs[7]  = mk(1, 0, 32'h240, 0,            5, 1, 32'hA500_0240, 4, 4);
    vecs[8]  = mk(1, 0, 32'h640, 0,            8, 1, 32'hA500_0640, 4, 5);
    vecs[9]  = mk(1, 0, 32'h044, 0,            5, 1, 32'hDEADBEEF,  4, 6);
    vecs[10] = mk(0, 1, 32'h848, 32'h12345678, 5, 0, 0,             4, 7);
    vecs[11] = mk(1, 0, 32'h848, 0,            0, 1, 32'h12345678,  5, 7);
    vecs[12] = mk(1, 0, 32'h1000, 0,           5, 1, 32'hA500_1000, 5, 8);
    vecs[13] = mk(1, 1, 32'h1004, 32'hCAFEF00D, 0, 1, 0,            6, 8);
    vecs[14] = mk(1, 0, 32'h1004, 0,           0, 1, 32'hCAFEF00D,  7, 8);

    #12;
    chk("rst_hit_cnt",  256'(hit_cnt_o), 0);
    chk("rst_miss_cnt", 256'(miss_cnt_o), 0);
    chk("rst_stall",    256'(cpu_stall_o), 0);
    chk("rst_mem_en",   256'(mem_enable_o), 0);
    chk("rst_mem_we",   256'(mem_write_o), 0);
    chk("rst_mem_addr", 256'(mem_addr_o), 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_cpu_data", 256'(cpu_data_o), 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 15; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rdat);
      chk($sformatf("v%0d_stall", i), 256'(st), 256'(vecs[i].stall));
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), 256'(rdat), 256'(vecs[i].rdata));
      chk($sformatf("v%0d_hit_cnt", i), 256'(hit_cnt_o), 256'(vecs[i].hit));
      chk($sformatf("v%0d_miss_cnt", i), 256'(miss_cnt_o), 256'(vecs[i].miss));
      if (i == 0) begin
        chk("cold_log_len", 256'(loga.size()), 1);
        if (loga.size() >= 1) begin
          chk("cold_mem_we",   256'(logw[0]), 0);
          chk("cold_mem_addr", 256'(loga[0]), 256'(32'h40));
        end
      end
    end

    // Dirty eviction of 0x040: write-back then refill of 0x640.
    wb_line = pat(32'h040);
    wb_line[63:32] = 32'hDEADBEEF;
    chk("log_len", 256'(loga.size()), 9);
    if (loga.size() >= 6) begin
      chk("wb_we",      256'(logw[4]), 1);
      chk("wb_addr",    256'(loga[4]), 256'(32'h040));
      chk("wb_data",    logd[4], wb_line);
      chk("wb_rf_we",   256'(logw[5]), 0);
      chk("wb_rf_addr", 256'(loga[5]), 256'(32'h640));
    end

    // Reset in the middle of a refill.
    lat = 10;
    cpu_addr_i = 32'h2000; cpu_MemRead_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("rf_mem_en",   256'(mem_enable_o), 1);
    chk("rf_mem_we",   256'(mem_write_o), 0);
    chk("rf_mem_addr", 256'(mem_addr_o), 256'(32'h2000));
    rst_i = 1'b0;
    #1;
    chk("rstmid_mem_en",   256'(mem_enable_o), 0);
    chk("rstmid_mem_addr", 256'(mem_addr_o), 0);
    chk("rstmid_miss_cnt", 256'(miss_cnt_o), 0);
    chk("rstmid_hit_cnt",  256'(hit_cnt_o), 0);
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    lat = 3;
    @(posedge clk_i); #1;
    access(1, 0, 32'h848, 0, st, rdat);
    chk("postrst_stall",    256'(st), 5);
    chk("postrst_rdata",    256'(rdat), 256'(32'hA500_0848));
    chk("postrst_miss_cnt", 256'(miss_cnt_o), 1);
    chk("postrst_hit_cnt",  256'(hit_cnt_o), 0);

    // Saturation of the hit counter.
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_cnt_q;
    @(posedge clk_i); #1;
    access(1, 0, 32'h848, 0, st, rdat);
    chk("sat_stall",   256'(st), 0);
    chk("sat_hit_cnt", 256'(hit_cnt_o), 256'(32'hFFFF_FFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
